// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks a KHxKW window over the input map, feeds a subkernel MAC and writes results in raster order
module conv_window_scheduler #(
    parameter int INWIDTH       = 8,
    parameter int OUTWIDTH      = 16,
    parameter int KERNEL_WIDTH  = 4,
    parameter int KERNEL_HEIGHT = 3,
    parameter int IMG_WIDTH     = 8,
    parameter int IMG_HEIGHT    = 6,
    parameter int ADDR_BITS     = 6
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           mem_rd_en,
    output logic [ADDR_BITS-1:0]                           mem_addr,
    input  logic [INWIDTH-1:0]                             mem_rd_data,
    output logic                                           sk_start,
    output logic [KERNEL_WIDTH*KERNEL_HEIGHT*INWIDTH-1:0]  sk_x,
    input  logic                                           sk_done,
    input  logic [OUTWIDTH-1:0]                            sk_out,
    output logic                                           out_valid,
    output logic [ADDR_BITS-1:0]                           out_addr,
    output logic [OUTWIDTH-1:0]                            out_data
);
    localparam int KW = KERNEL_WIDTH;
    localparam int KH = KERNEL_HEIGHT;
    localparam int N  = KW * KH;
    localparam int OW = IMG_WIDTH - KW + 1;
    localparam int OH = IMG_HEIGHT - KH + 1;
    localparam int XW = N * INWIDTH;
    localparam int RB = $clog2(KH + 1);
    localparam int CB = $clog2(KW + 1);
    localparam int XB = $clog2(OW + 1);
    localparam int YB = $clog2(OH + 1);
    localparam int IB = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_FIRE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [RB-1:0]       r_q, r_d;
    logic [CB-1:0]       c_q, c_d;
    logic [XB-1:0]       ox_q, ox_d;
    logic [YB-1:0]       oy_q, oy_d;
    logic [XW-1:0]       sk_x_q, sk_x_d;
    logic [OUTWIDTH-1:0] out_data_q, out_data_d;
    logic                cap_en;
    logic [IB-1:0]       cap_i;
    logic                last_c, last_r, last_x, last_y;

    assign last_c    = c_q == CB'(KW - 1);
    assign last_r    = r_q == RB'(KH - 1);
    assign last_x    = ox_q == XB'(OW - 1);
    assign last_y    = oy_q == YB'(OH - 1);
    assign busy      = state_q != S_IDLE && state_q != S_DONE;
    assign done      = state_q == S_DONE;
    assign mem_rd_en = state_q == S_FETCH;
    assign sk_start  = state_q == S_FIRE;
    assign out_valid = state_q == S_WRITE;
    assign mem_addr  = mem_rd_en ? ADDR_BITS'((int'(oy_q) + int'(r_q)) * IMG_WIDTH + int'(ox_q) + int'(c_q)) : '0;
    assign out_addr  = out_valid ? ADDR_BITS'(int'(oy_q) * OW + int'(ox_q)) : '0;
    assign sk_x      = sk_x_q;
    assign out_data  = out_data_q;

    // Memory data lags the address by one cycle, so each fetch cycle stores the previous element; LOAD stores the last one
    always_comb begin
        cap_en = (state_q == S_FETCH && (r_q != '0 || c_q != '0)) || state_q == S_LOAD;
        cap_i  = state_q == S_LOAD ? IB'(N - 1) : IB'(int'(r_q) * KW + int'(c_q) - 1);
        sk_x_d = sk_x_q;
        for (int i = 0; i < N; i++)
            if (cap_en && cap_i == IB'(i)) sk_x_d[(N-1-i)*INWIDTH +: INWIDTH] = mem_rd_data;
    end

    // Frame sequencing: fetch window, fire subkernel, wait for result, write, advance raster position
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                r_d     = '0;
                c_d     = '0;
                ox_d    = '0;
                oy_d    = '0;
            end
            S_FETCH: begin
                c_d = last_c ? '0 : c_q + 1'b1;
                if (last_c) r_d = last_r ? '0 : r_q + 1'b1;
                if (last_c && last_r) state_d = S_LOAD;
            end
            S_LOAD:  state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT: if (sk_done) begin
                out_data_d = sk_out;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                ox_d    = last_x ? '0 : ox_q + 1'b1;
                if (last_x) oy_d = last_y ? '0 : oy_q + 1'b1;
                state_d = (last_x && last_y) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset wins in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            sk_x_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            sk_x_q     <= sk_x_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: random-stimulus bench with a window-level reference model and a subkernel/memory model
module tb_conv_window_scheduler;
    logic        clk = 0, reset = 1, start = 0;
    logic        busy, done, mem_rd_en, sk_start, out_valid;
    logic [5:0]  mem_addr, out_addr;
    logic [7:0]  mem_rd_data = 0;
    logic [95:0] sk_x;
    logic        sk_done = 0;
    logic [15:0] sk_out = 0, out_data;

    conv_window_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .sk_start(sk_start), .sk_x(sk_x), .sk_done(sk_done), .sk_out(sk_out),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  img [0:47];
    int          total = 0, bad = 0;
    int          exp_rd[$], exp_wa[$], rec_rd[$];
    logic [15:0] exp_wd[$];
    logic [95:0] exp_x[$];
    int          wr_cnt = 0, done_cnt = 0, st_cnt = 0, cnt = 0, dly_mode = 0;
    logic        prev_valid = 0, pend = 0, spur = 0;
    logic [95:0] snap = 0, first_x = 0;
    logic [15:0] sum = 0, first_d = 0, last_d = 0;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_addr];

    task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected traffic of a whole frame computed straight from the image
    task automatic build_frame();
        logic [95:0] x;
        logic [15:0] s;
        int a;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_x.delete();
        wr_cnt = 0;
        for (int oy = 0; oy < 4; oy++)
            for (int ox = 0; ox < 5; ox++) begin
                x = 0;
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 4; c++) begin
                        a = (oy + r) * 8 + ox + c;
                        exp_rd.push_back(a);
                        x = {x[87:0], img[a]};
                        s = s + 16'(img[a]);
                    end
                exp_x.push_back(x);
                exp_wa.push_back(oy * 5 + ox);
                exp_wd.push_back(s);
            end
    endtask

    task automatic rand_img();
        for (int i = 0; i < 48; i++) img[i] = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input bit spam);
        int n = 0;
        while (!done && n < 3000) begin
            start = spam && n[0] && wr_cnt < 19;
            tick();
            n++;
        end
        start = 0;
        chk("done_timeout", done, 1);
    endtask

    // Per-cycle compare against the model, followed by the subkernel model driving sk_done/sk_out
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_x.delete();
            cnt = 0; pend = 0; prev_valid = 0; sk_done = 0;
        end else begin
            if (mem_rd_en) begin
                chk("rd_busy", busy, 1);
                chk("rd_unexp", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) chk("rd_addr", mem_addr, exp_rd.pop_front());
                if (rec_rd.size() < 12) rec_rd.push_back(int'(mem_addr));
            end
            if (sk_start) begin
                st_cnt++;
                chk("start_busy", busy, 1);
                chk("x_unexp", exp_x.size() > 0, 1);
                if (exp_x.size() > 0) chk("sk_x", sk_x, exp_x.pop_front());
                if (st_cnt == 1) first_x = sk_x;
            end
            if (pend && !sk_start) chk("x_stable", sk_x, snap);
            if (out_valid) begin
                chk("wr_after_done", sk_done, 1);
                chk("wr_unexp", exp_wa.size() > 0, 1);
                if (exp_wa.size() > 0) begin
                    chk("out_addr", out_addr, exp_wa.pop_front());
                    chk("out_data", out_data, exp_wd.pop_front());
                end
                if (out_addr == 0) first_d = out_data;
                if (out_addr == 19) last_d = out_data;
                wr_cnt++;
            end
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_pos", {prev_valid, wr_cnt == 20, exp_wa.size() == 0}, 3'b111);
                done_cnt++;
            end
            prev_valid = out_valid;
            sk_done = 0;
            if (sk_start) begin
                snap = sk_x;
                pend = 1;
                cnt = dly_mode != 0 ? int'($urandom_range(9, 1)) : 4;
                sum = 0;
                for (int i = 0; i < 12; i++) sum = sum + 16'(sk_x[i*8 +: 8]);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sk_done = 1;
                    sk_out = sum;
                    pend = 0;
                end
            end
            if (spur) begin
                sk_done = 1;
                sk_out = 16'hdead;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit_rd[12] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19};
        logic [95:0] lit_x;
        int d0;
        lit_x = 96'h01020304_090a0b0c_11121314;
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) img[y*8+x] = 8'(y * 8 + x + 1);

        // Reset held 3 cycles with start asserted
        reset = 1; start = 1;
        repeat (3) tick();
        reset = 0; start = 0;
        tick();
        chk("rst_outs", {busy, done, sk_start, out_valid, mem_rd_en}, 0);
        chk("rst_sk_x", sk_x, 0);
        tick();
        chk("rst_start_ignored", {busy, mem_rd_en}, 0);

        // Ramp image, fixed 4-cycle subkernel
        dly_mode = 0; st_cnt = 0; rec_rd.delete();
        build_frame();
        pulse_start();
        wait_done(0);
        tick();
        chk("f1_nreads", rec_rd.size(), 12);
        for (int i = 0; i < 12; i++) chk("f1_rd_lit", rec_rd[i], lit_rd[i]);
        chk("f1_x_lit", first_x, lit_x);
        chk("f1_first_sum", first_d, 126);
        chk("f1_last_sum", last_d, 462);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_wr_cnt", wr_cnt, 20);

        // Random image, random subkernel latency, then a stray sk_done while idle
        rand_img(); dly_mode = 1;
        build_frame();
        pulse_start();
        wait_done(0);
        tick();
        chk("f2_done_cnt", done_cnt, 2);
        spur = 1;
        tick();
        spur = 0;
        tick();
        tick();
        chk("spur_no_write", {out_valid, busy}, 0);
        chk("spur_wr_cnt", wr_cnt, 20);

        // start spammed while busy, then start in DONE (ignored) and again the next cycle (accepted)
        rand_img();
        build_frame();
        pulse_start();
        wait_done(1);
        start = 1;
        tick();
        chk("done_start_ignored", {busy, mem_rd_en}, 0);
        chk("f3_done_cnt", done_cnt, 3);
        rand_img();
        build_frame();
        rec_rd.delete();
        tick();
        start = 0;
        wait_done(0);
        tick();
        chk("f4_first_rd", rec_rd[0], 0);
        chk("f4_done_cnt", done_cnt, 4);

        // Reset in the WAIT of window 7 abandons the frame
        rand_img(); dly_mode = 0; st_cnt = 0;
        build_frame();
        pulse_start();
        for (int n = 0; n < 2000 && st_cnt < 7; n++) tick();
        chk("w7_reached", st_cnt, 7);
        d0 = done_cnt;
        reset = 1;
        tick();
        chk("mid_rst_outs", {busy, done, sk_start, out_valid, mem_rd_en, mem_addr, out_addr, out_data}, 0);
        chk("mid_rst_sk_x", sk_x, 0);
        reset = 0;
        repeat (10) tick();
        chk("mid_rst_no_done", done_cnt, d0);
        chk("mid_rst_idle", busy, 0);
        rand_img(); dly_mode = 1; rec_rd.delete();
        build_frame();
        pulse_start();
        wait_done(0);
        tick();
        chk("f6_first_rd", rec_rd[0], 0);
        chk("f6_done_cnt", done_cnt, d0 + 1);
        chk("f6_wr_cnt", wr_cnt, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
